// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage ALU with an iterative radix-2 multiply/divide
// unit and the architectural HI/LO registers.
module ex_muldiv #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   inst_valid,
   input  logic [5:0]             funct,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   input  logic [DATA_WIDTH-1:0]  operand_1,
   input  logic [DATA_WIDTH-1:0]  operand_2,
   input  logic                   reg_write_en_in,
   input  logic [4:0]             reg_write_addr_in,
   output logic [DATA_WIDTH-1:0]  result,
   output logic                   reg_write_en_out,
   output logic [4:0]             reg_write_addr_out,
   output logic                   stall_req,
   output logic                   busy,
   output logic [DATA_WIDTH-1:0]  hi_out,
   output logic [DATA_WIDTH-1:0]  lo_out
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_JALR  = 6'h09;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   dvsr_q;
   logic [W-1:0]   op1_q;
   logic [W-1:0]   hi_q, lo_q;
   logic [2*W:0]   acc_q, acc_step;
   logic           div_q, neg_q, neg_rem_q, dz_q;

   logic           is_mul, is_div, is_mt, is_signed, start;
   logic           sgn_1, sgn_2;
   logic [W-1:0]   mag_1, mag_2;
   logic [W:0]     mul_sum, div_trial;
   logic [2*W:0]   div_shift;
   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0]   quo, rem, hi_res, lo_res;
   logic [SHAMT_WIDTH-1:0] shv;

   assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div    = (funct == F_DIV) || (funct == F_DIVU);
   assign is_mt     = (funct == F_MTHI) || (funct == F_MTLO);
   assign is_signed = (funct == F_MULT) || (funct == F_DIV);
   assign start     = inst_valid & ~flush & (is_mul | is_div);

   assign sgn_1 = is_signed & operand_1[W-1];
   assign sgn_2 = is_signed & operand_2[W-1];
   assign mag_1 = sgn_1 ? -operand_1 : operand_1;
   assign mag_2 = sgn_2 ? -operand_2 : operand_2;
   assign shv   = operand_1[SHAMT_WIDTH-1:0];

   assign busy      = (state_q != S_IDLE);
   assign stall_req = ((state_q == S_IDLE) & start) |
                      (state_q == S_MUL) | (state_q == S_DIV);

   assign reg_write_en_out   = reg_write_en_in & ~flush &
                               ~(is_mul | is_div | is_mt);
   assign reg_write_addr_out = reg_write_addr_in;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

   // next state; flush always returns the unit to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = is_mul ? S_MUL : S_DIV;
         S_MUL,
         S_DIV:   if (cnt_q == LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // one shift-add or restoring-subtract step, plus sign fix-up
   always_comb begin
      mul_sum   = acc_q[2*W:W] + {1'b0, (acc_q[0] ? dvsr_q : '0)};
      div_shift = {acc_q[2*W-1:0], 1'b0};
      div_trial = div_shift[2*W:W] - {1'b0, dvsr_q};
      acc_step  = acc_q;
      if (state_q == S_MUL)
         acc_step = {1'b0, mul_sum, acc_q[W-1:1]};
      else if (state_q == S_DIV)
         acc_step = div_trial[W] ? div_shift :
                    {div_trial, div_shift[W-1:1], 1'b1};
      prod     = acc_q[2*W-1:0];
      prod_fix = neg_q ? -prod : prod;
      quo      = acc_q[W-1:0];
      rem      = acc_q[2*W-1:W];
      hi_res   = prod_fix[2*W-1:W];
      lo_res   = prod_fix[W-1:0];
      if (div_q) begin
         if (dz_q) begin
            hi_res = op1_q;
            lo_res = '1;
         end else begin
            hi_res = neg_rem_q ? -rem : rem;
            lo_res = neg_q ? -quo : quo;
         end
      end
   end

   // operand capture on start, one iteration per cycle afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         dvsr_q    <= '0;
         op1_q     <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            cnt_q     <= '0;
            acc_q     <= {{(W+1){1'b0}}, mag_1};
            dvsr_q    <= mag_2;
            op1_q     <= operand_1;
            div_q     <= is_div;
            neg_q     <= sgn_1 ^ sgn_2;
            neg_rem_q <= sgn_1;
            dz_q      <= is_div & (operand_2 == '0);
         end
      end else if (state_q == S_MUL || state_q == S_DIV) begin
         acc_q <= acc_step;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // HI/LO: result write at the close of DONE, MTHI/MTLO when not stalled;
   // the move is younger in program order so it wins on a collision
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!flush) begin
         if (state_q == S_DONE) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
         end
         if (inst_valid && !stall_req) begin
            if (funct == F_MTHI) hi_q <= operand_1;
            if (funct == F_MTLO) lo_q <= operand_1;
         end
      end
   end

   // combinational ALU and HI/LO read
   always_comb begin
      result = '0;
      case (funct)
         F_ADDU: result = operand_1 + operand_2;
         F_SUBU: result = operand_1 - operand_2;
         F_AND:  result = operand_1 & operand_2;
         F_OR:   result = operand_1 | operand_2;
         F_XOR:  result = operand_1 ^ operand_2;
         F_NOR:  result = ~(operand_1 | operand_2);
         F_SLT:  result = {{(W-1){1'b0}},
                           $signed(operand_1) < $signed(operand_2)};
         F_SLTU: result = {{(W-1){1'b0}}, operand_1 < operand_2};
         F_SLL:  result = operand_2 << shamt;
         F_SLLV: result = operand_2 << shv;
         F_SRL:  result = operand_2 >> shamt;
         F_SRLV: result = operand_2 >> shv;
         F_SRA:  result = $signed(operand_2) >>> shamt;
         F_SRAV: result = $signed(operand_2) >>> shv;
         F_JALR: result = operand_1 | operand_2;
         F_MFHI: result = hi_q;
         F_MFLO: result = lo_q;
         default: result = '0;
      endcase
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized scoreboard bench for ex_muldiv against an
// arithmetic reference model.
module tb_ex_muldiv;
   localparam int W = 32;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          inst_valid = 1'b0;
   logic [5:0]    funct = '0;
   logic [4:0]    shamt = '0;
   logic [W-1:0]  operand_1 = '0, operand_2 = '0;
   logic          reg_write_en_in = 1'b0;
   logic [4:0]    reg_write_addr_in = '0;
   logic [W-1:0]  result, hi_out, lo_out;
   logic          reg_write_en_out, stall_req, busy;
   logic [4:0]    reg_write_addr_out;

   logic          n_flush = 1'b0;
   logic          n_valid = 1'b0;
   logic [5:0]    n_funct = '0;
   logic [3:0]    n_shamt = '0;
   logic [15:0]   n_op1 = '0, n_op2 = '0;
   logic          n_wen_in = 1'b0;
   logic [4:0]    n_addr_in = '0;
   logic [15:0]   n_result, n_hi, n_lo;
   logic          n_wen, n_stall, n_busy;
   logic [4:0]    n_addr;

   ex_muldiv #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid),
      .funct(funct), .shamt(shamt),
      .operand_1(operand_1), .operand_2(operand_2),
      .reg_write_en_in(reg_write_en_in),
      .reg_write_addr_in(reg_write_addr_in),
      .result(result), .reg_write_en_out(reg_write_en_out),
      .reg_write_addr_out(reg_write_addr_out),
      .stall_req(stall_req), .busy(busy),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   ex_muldiv #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .flush(n_flush), .inst_valid(n_valid),
      .funct(n_funct), .shamt(n_shamt),
      .operand_1(n_op1), .operand_2(n_op2),
      .reg_write_en_in(n_wen_in), .reg_write_addr_in(n_addr_in),
      .result(n_result), .reg_write_en_out(n_wen),
      .reg_write_addr_out(n_addr),
      .stall_req(n_stall), .busy(n_busy),
      .hi_out(n_hi), .lo_out(n_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           stalls;
   } md_exp_t;

   typedef struct {
      logic [W-1:0] res;
      logic         wen;
      logic [4:0]   addr;
   } alu_exp_t;

   md_exp_t  md_q[$];
   alu_exp_t alu_q[$];
   md_exp_t  me;
   alu_exp_t ae;

   int tests = 0;
   int fails = 0;
   logic mon_en = 1'b0;
   logic chk_alu = 1'b0;
   logic prev_busy = 1'b0;
   int stall_cnt = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic void md_model(input logic [5:0] f,
                                    input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] hi,
                                    output logic [W-1:0] lo);
      longint p, q, r;
      longint unsigned pu, qu, ru;
      hi = '0;
      lo = '0;
      case (f)
         F_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32];
            lo = p[31:0];
         end
         F_MULTU: begin
            pu = {32'h0, a} * {32'h0, b};
            hi = pu[63:32];
            lo = pu[31:0];
         end
         F_DIV: begin
            if (b == 0) begin
               hi = a;
               lo = '1;
            end else begin
               q = longint'($signed(a)) / longint'($signed(b));
               r = longint'($signed(a)) % longint'($signed(b));
               hi = r[31:0];
               lo = q[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               hi = a;
               lo = '1;
            end else begin
               qu = {32'h0, a} / {32'h0, b};
               ru = {32'h0, a} % {32'h0, b};
               hi = ru[31:0];
               lo = qu[31:0];
            end
         end
      endcase
   endfunction

   function automatic logic [W-1:0] alu_model(input logic [5:0] f,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [4:0] sh,
                                              input logic [W-1:0] hi,
                                              input logic [W-1:0] lo);
      int unsigned sv;
      logic [W-1:0] fill;
      sv = a % 32;
      case (f)
         6'h21: return a + b;
         6'h23: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h2A: return (int'(a) < int'(b)) ? 1 : 0;
         6'h2B: return (a < b) ? 1 : 0;
         6'h00: return b << sh;
         6'h04: return b << sv;
         6'h02: return b >> sh;
         6'h06: return b >> sv;
         6'h03: begin
            fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
            return (b >> sh) | fill;
         end
         6'h07: begin
            fill = b[31] ? ~(32'hFFFF_FFFF >> sv) : 32'h0;
            return (b >> sv) | fill;
         end
         6'h09: return a | b;
         6'h10: return hi;
         6'h12: return lo;
         default: return '0;
      endcase
   endfunction

   // monitor: pop an expectation whenever the unit goes idle or an ALU
   // instruction is presented
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_busy && !busy) begin
            if (md_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL md_unexpected: got idle, want no event");
            end else begin
               me = md_q.pop_front();
               chk("md_hi", hi_out, me.hi);
               chk("md_lo", lo_out, me.lo);
               if (me.stalls >= 0) chk("md_stalls", stall_cnt, me.stalls);
            end
            stall_cnt = 0;
         end
         if (stall_req) stall_cnt++;
         if (chk_alu) begin
            if (alu_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL alu_empty: got check, want queued item");
            end else begin
               ae = alu_q.pop_front();
               chk("alu_result", result, ae.res);
               chk("alu_wen", {31'h0, reg_write_en_out}, {31'h0, ae.wen});
               chk("alu_addr", {27'h0, reg_write_addr_out}, {27'h0, ae.addr});
            end
         end
      end
      prev_busy = busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_md(input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b);
      logic [W-1:0] eh, el;
      md_model(f, a, b, eh, el);
      md_q.push_back('{eh, el, W + 1});
      m_hi = eh;
      m_lo = el;
      inst_valid = 1'b1;
      funct = f;
      operand_1 = a;
      operand_2 = b;
      reg_write_en_in = 1'b1;
      tick();
      inst_valid = 1'b0;
      funct = 6'h00;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk("md_done_idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic alu_op(input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh,
                         input logic wen, input logic [4:0] addr);
      logic is_mt;
      is_mt = (f == F_MTHI) || (f == F_MTLO);
      alu_q.push_back('{alu_model(f, a, b, sh, m_hi, m_lo),
                        wen & ~is_mt, addr});
      inst_valid = 1'b1;
      funct = f;
      operand_1 = a;
      operand_2 = b;
      shamt = sh;
      reg_write_en_in = wen;
      reg_write_addr_in = addr;
      chk_alu = 1'b1;
      tick();
      chk_alu = 1'b0;
      inst_valid = 1'b0;
      if (f == F_MTHI) m_hi = a;
      if (f == F_MTLO) m_lo = a;
   endtask

   logic [5:0] alu_ops [20] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h27, 6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07,
      6'h09, 6'h10, 6'h12, 6'h11, 6'h13, 6'h3F};

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] a, b;
      int ns;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_stall", {31'h0, stall_req}, 32'h0);
      tick();

      start_md(F_MULT, 32'hFFFF_FFFE, 32'd3);  wait_idle();
      start_md(F_MULTU, 32'hFFFF_FFFE, 32'd3); wait_idle();
      start_md(F_DIV, 32'hFFFF_FFF9, 32'd2);   wait_idle();
      start_md(F_DIVU, 32'd7, 32'd0);          wait_idle();
      start_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      start_md(F_DIV, 32'hFFFF_FFF9, 32'd0);   wait_idle();

      alu_op(F_MTHI, 32'h0000_1234, 32'h0, 5'd0, 1'b1, 5'd3);
      alu_op(F_MFHI, 32'h0, 32'h0, 5'd0, 1'b1, 5'd4);
      alu_op(F_MTLO, 32'hCAFE_0001, 32'h0, 5'd0, 1'b1, 5'd5);
      alu_op(F_MFLO, 32'h0, 32'h0, 5'd0, 1'b1, 5'd6);

      // flush at iteration 10: HI/LO keep their values
      md_q.push_back('{m_hi, m_lo, 12});
      inst_valid = 1'b1; funct = F_MULT;
      operand_1 = 32'h1357_9BDF; operand_2 = 32'h2468_ACE0;
      tick();
      inst_valid = 1'b0; funct = 6'h00;
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {31'h0, busy}, 32'h0);
      chk("flush_stall", {31'h0, stall_req}, 32'h0);

      // a move presented while stalled must be ignored
      start_md(F_MULTU, 32'h0001_0003, 32'h0000_0100);
      repeat (3) tick();
      inst_valid = 1'b1; funct = F_MTLO; operand_1 = 32'hDEAD_BEEF;
      tick();
      inst_valid = 1'b0; funct = 6'h00;
      wait_idle();

      // flush beats a simultaneous start
      inst_valid = 1'b1; funct = F_MULT; flush = 1'b1;
      reg_write_en_in = 1'b1;
      @(negedge clk);
      chk("flush_start_stall", {31'h0, stall_req}, 32'h0);
      chk("flush_wen", {31'h0, reg_write_en_out}, 32'h0);
      tick();
      flush = 1'b0; inst_valid = 1'b0; funct = 6'h00;
      chk("flush_start_busy", {31'h0, busy}, 32'h0);

      // reset at iteration 5 clears HI/LO
      md_q.push_back('{32'h0, 32'h0, 7});
      inst_valid = 1'b1; funct = F_DIV;
      operand_1 = 32'h7FFF_0000; operand_2 = 32'h0000_0013;
      tick();
      inst_valid = 1'b0; funct = 6'h00;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);
      chk("rst_mid_hi", hi_out, 32'h0);
      chk("rst_mid_lo", lo_out, 32'h0);

      for (int i = 0; i < 60; i++) begin
         alu_op(alu_ops[$urandom_range(0, 19)], $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom),
                5'($urandom_range(0, 31)));
      end

      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         start_md(6'(F_MULT + 6'($urandom_range(0, 3))), a, b);
         wait_idle();
         alu_op(($urandom_range(0, 1) != 0) ? F_MFHI : F_MFLO,
                32'h0, 32'h0, 5'd0, 1'b1, 5'd7);
      end

      // 16-bit instance: MULTU 0xFFFF x 0xFFFF
      ns = 0;
      n_valid = 1'b1; n_funct = F_MULTU;
      n_op1 = 16'hFFFF; n_op2 = 16'hFFFF;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (n_stall) ns++;
         tick();
         n_valid = 1'b0;
         n_funct = 6'h00;
         if (!n_busy) break;
      end
      chk("w16_busy", {31'h0, n_busy}, 32'h0);
      chk("w16_hi", {16'h0, n_hi}, 32'h0000_FFFE);
      chk("w16_lo", {16'h0, n_lo}, 32'h0000_0001);
      chk("w16_stalls", ns, 32'd17);

      repeat (4) tick();
      chk("sb_md_empty", md_q.size(), 32'd0);
      chk("sb_alu_empty", alu_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result/HI/LO width; SHALL be even and >= 8.
REQ-002 Parameter SHAMT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 Port list SHALL be exactly REQ-004 to REQ-018, in this order.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  kill current instruction/iteration.
REQ-007 inst_valid  in  1  ID presents a valid instruction.
REQ-008 funct  in  6  MIPS R-type funct code.
REQ-009 shamt  in  SHAMT_WIDTH  immediate shift amount.
REQ-010 operand_1, operand_2  in  DATA_WIDTH each  rs/rt values.
REQ-011 reg_write_en_in  in  1;  reg_write_addr_in  in  5  destination info.
REQ-012 result  out  DATA_WIDTH  combinational ALU/MF result.
REQ-013 reg_write_en_out  out  1;  reg_write_addr_out  out  5.
REQ-014 stall_req  out  1  pipeline hold request to ID/IF.
REQ-015 busy  out  1  high in states MUL, DIV, DONE.
REQ-016 hi_out  out  DATA_WIDTH  architectural HI register.
REQ-017 lo_out  out  DATA_WIDTH  architectural LO register.
REQ-018 reg_write_addr_out SHALL equal reg_write_addr_in.

Function
REQ-019 ALU functs ADDU/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SLLV/SRL/SRLV/SRA/SRAV/JALR SHALL produce DATA_WIDTH results combinationally; variable shifts use operand_1[SHAMT_WIDTH-1:0]; SRA/SRAV arithmetic; SLT signed, SLTU unsigned; JALR = operand_1|operand_2.
REQ-020 MFHI(0x10)/MFLO(0x12) SHALL drive result = hi_out/lo_out; unknown functs drive 0.
REQ-021 MTHI(0x11)/MTLO(0x13) SHALL write operand_1 to HI/LO at the edge where inst_valid=1, stall_req=0, flush=0.
REQ-022 reg_write_en_out SHALL be 0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO and during flush, else reg_write_en_in.
REQ-023 FSM states IDLE, MUL, DIV, DONE.
REQ-024 IDLE -> MUL on inst_valid & !flush & funct MULT(0x18)/MULTU(0x19); IDLE -> DIV on DIV(0x1A)/DIVU(0x1B); entry latches operand magnitudes (absolute value for signed), sign flags, iteration counter 0.
REQ-025 MUL/DIV SHALL perform one radix-2 shift-add / restoring-subtract step per cycle; after DATA_WIDTH steps -> DONE.
REQ-026 DONE SHALL apply sign correction, write HI/LO at its closing edge, then return to IDLE.
REQ-027 stall_req SHALL be combinationally 1 in IDLE on a starting mul/div and in MUL/DIV; 0 in DONE; total stall = DATA_WIDTH+1 cycles.
REQ-028 Multiply: {HI,LO} = 2*DATA_WIDTH-bit product; signed result negated iff operand signs differ.
REQ-029 Divide: LO=quotient, HI=remainder; quotient negative iff signs differ; remainder takes dividend sign.
REQ-030 Divide by zero: LO = all ones, HI = original operand_1; no exception, same latency.
REQ-031 Signed MIN / -1: LO = MIN, HI = 0.
REQ-032 flush in any state SHALL force IDLE at next edge, HI/LO unchanged, stall_req 0 from next cycle; flush wins over a simultaneous start.
REQ-033 MTHI/MTLO are never accepted while stall_req=1.

Reset
REQ-034 rst SHALL set state IDLE, counter 0, HI=LO=0; stall_req=0, busy=0, hi_out=lo_out=0 in the following cycle.
REQ-035 rst SHALL override flush and any start, including mid-operation.

Verification (DATA_WIDTH=32 unless stated)
REQ-036 MULT 0xFFFFFFFE x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_req high exactly 33 cycles.
REQ-037 MULTU 0xFFFFFFFE x 3 -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-038 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-040 flush at iteration 10 -> IDLE next cycle, HI/LO keep prior values; rst at iteration 5 -> HI=LO=0, busy=0.
REQ-041 MTHI 0x1234 then MFHI -> result 0x00001234; DATA_WIDTH=16 MULTU 0xFFFF x 0xFFFF -> HI=0xFFFE, LO=0x0001, 17 stall cycles.
